// File: rtl/apb_reg_pkg.sv
// rtl/apb_reg_pkg.sv - shared types and widths for the APB register bank
package apb_reg_pkg;

    // Transfer FSM: waiting for a setup phase, or inside the access phase
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Wide enough for WAIT_STATES up to 15
    localparam int WAIT_CNT_W = 4;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_REGWN  = 5;
    localparam int DEF_REGRN  = 3;

endpackage

// File: rtl/apb_wait_cnt.sv
// rtl/apb_wait_cnt.sv - loadable wait-state down-counter with zero flag
module apb_wait_cnt
    import apb_reg_pkg::*;
(
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] r_cnt;

    // Load wins over decrement; the count saturates at zero
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - APB register bank with RW/RO registers, wait states and strobes
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int                DWIDTH      = DEF_DWIDTH,
    parameter int                REGWN       = DEF_REGWN,
    parameter int                REGRN       = DEF_REGRN,
    parameter int                WAIT_STATES = 1,
    parameter logic [DWIDTH-1:0] RW_RESET    = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DWIDTH-1:0]       PWDATA,
    input  logic [REGWN-1:0]        pselw,
    input  logic [REGRN-1:0]        pselr,
    input  logic [REGRN*DWIDTH-1:0] ro_data_i,
    output logic [DWIDTH-1:0]       PRDATA,
    output logic                    PREADY,
    output logic [REGWN*DWIDTH-1:0] rw_data_o,
    output logic [REGWN-1:0]        wr_pulse_o,
    output logic [REGRN-1:0]        rd_pulse_o
);

    state_t                        r_state;
    state_t                        w_next_state;
    logic                          r_is_read;
    logic [DWIDTH-1:0]             r_snap;
    logic [REGWN-1:0][DWIDTH-1:0]  r_rw;
    logic [REGWN-1:0]              r_wr_pulse;
    logic [REGRN-1:0]              r_rd_pulse;
    logic [DWIDTH-1:0]             w_rd_mux;
    logic                          w_zero;
    logic                          w_load;
    logic                          w_complete;

    assign w_load     = (r_state == IDLE) && PSEL && !PENABLE;
    assign w_complete = (r_state == ACCESS) && PSEL && PENABLE && w_zero;

    apb_wait_cnt u_wait_cnt (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .load     (w_load),
        .load_val (WAIT_CNT_W'(WAIT_STATES)),
        .dec      (r_state == ACCESS),
        .zero     (w_zero)
    );

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: enter on setup, leave on completion or when PSEL drops (abort)
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (PSEL && !PENABLE) w_next_state = ACCESS;
            ACCESS:  if (!PSEL || (PENABLE && w_zero)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        PREADY = (r_state == ACCESS) && w_zero;
        PRDATA = ((r_state == ACCESS) && r_is_read) ? r_snap : '0;
    end

    // Read mux: scanned high to low so the lowest index wins, RW over RO
    always_comb begin
        w_rd_mux = '0;
        for (int k = REGRN - 1; k >= 0; k--) begin
            if (pselr[k]) w_rd_mux = ro_data_i[k*DWIDTH +: DWIDTH];
        end
        for (int k = REGWN - 1; k >= 0; k--) begin
            if (pselw[k]) w_rd_mux = r_rw[k];
        end
    end

    // Capture direction and read data at setup so later RO changes are invisible
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_is_read <= 1'b0;
            r_snap    <= '0;
        end else if (w_load) begin
            r_is_read <= !PWRITE;
            r_snap    <= PWRITE ? '0 : w_rd_mux;
        end
    end

    // RW register storage, written only on a completed write
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rw <= {REGWN{RW_RESET}};
        end else if (w_complete && !r_is_read) begin
            for (int k = 0; k < REGWN; k++) begin
                if (pselw[k]) r_rw[k] <= PWDATA;
            end
        end
    end

    // Single-cycle strobes following a completed transfer
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_pulse <= '0;
            r_rd_pulse <= '0;
        end else begin
            r_wr_pulse <= (w_complete && !r_is_read) ? pselw : '0;
            r_rd_pulse <= (w_complete &&  r_is_read) ? pselr : '0;
        end
    end

    assign rw_data_o  = r_rw;
    assign wr_pulse_o = r_wr_pulse;
    assign rd_pulse_o = r_rd_pulse;

endmodule

// File: tb/tb_apb_reg_bank.sv
// tb/tb_apb_reg_bank.sv - self-checking bench for apb_reg_bank at 0, 2 and 3 wait states
module tb_apb_reg_bank;

    localparam int NDUT = 3;

    logic            pclk;
    logic            presetn;
    logic [NDUT-1:0] psel;
    logic [NDUT-1:0] penable;
    logic [NDUT-1:0] pwrite;
    logic [7:0]      pwdata   [NDUT];
    logic [4:0]      pselw    [NDUT];
    logic [2:0]      pselr    [NDUT];
    logic [23:0]     ro_data  [NDUT];
    logic [7:0]      prdata   [NDUT];
    logic [NDUT-1:0] pready;
    logic [39:0]     rw_data  [NDUT];
    logic [4:0]      wr_pulse [NDUT];
    logic [2:0]      rd_pulse [NDUT];

    logic [7:0] m_rw [NDUT][5];
    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_reg_bank #(
            .DWIDTH      (8),
            .REGWN       (5),
            .REGRN       (3),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .RW_RESET    (8'h00)
        ) u_dut (
            .PCLK       (pclk),
            .PRESETn    (presetn),
            .PSEL       (psel[g]),
            .PENABLE    (penable[g]),
            .PWRITE     (pwrite[g]),
            .PWDATA     (pwdata[g]),
            .pselw      (pselw[g]),
            .pselr      (pselr[g]),
            .ro_data_i  (ro_data[g]),
            .PRDATA     (prdata[g]),
            .PREADY     (pready[g]),
            .rw_data_o  (rw_data[g]),
            .wr_pulse_o (wr_pulse[g]),
            .rd_pulse_o (rd_pulse[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < NDUT; d++)
            for (int k = 0; k < 5; k++) m_rw[d][k] = 8'h00;
    endfunction

    function automatic logic [39:0] exp_rw(input int d);
        logic [39:0] v;
        for (int k = 0; k < 5; k++) v[k*8 +: 8] = m_rw[d][k];
        return v;
    endfunction

    // Lowest selected index wins, RW registers before RO registers
    function automatic logic [7:0] model_read(input int d, input logic [4:0] sw, input logic [2:0] sr);
        for (int k = 0; k < 5; k++) if (sw[k]) return m_rw[d][k];
        for (int k = 0; k < 3; k++) if (sr[k]) return ro_data[d][k*8 +: 8];
        return 8'h00;
    endfunction

    task automatic idle_inputs(input int d);
        psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
        pwdata[d] = 8'h00; pselw[d] = '0; pselr[d] = '0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [4:0] sw, input logic [2:0] sr,
                        input logic [7:0] wd, input bit chg, input logic [23:0] new_ro);
        logic [7:0] exp_rd;
        int waits;
        @(negedge pclk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        pselw[d] = sw; pselr[d] = sr; pwdata[d] = wd;
        exp_rd = wr ? 8'h00 : model_read(d, sw, sr);
        @(posedge pclk); #1;
        if (chg) ro_data[d] = new_ro;
        @(negedge pclk);
        penable[d] = 1'b1;
        waits = 0;
        while (pready[d] !== 1'b1 && waits < 20) begin
            n_vec++;
            if (prdata[d] !== exp_rd) begin
                n_err++;
                $display("FAIL xfer_wait_prdata dut%0d: got %h expected %h", d, prdata[d], exp_rd);
            end
            @(negedge pclk);
            waits++;
        end
        n_vec++;
        if (waits !== ws_of(d)) begin
            n_err++;
            $display("FAIL xfer_latency dut%0d: got %0d wait cycles expected %0d", d, waits, ws_of(d));
        end
        n_vec++;
        if (prdata[d] !== exp_rd) begin
            n_err++;
            $display("FAIL xfer_prdata dut%0d: got %h expected %h", d, prdata[d], exp_rd);
        end
        if (wr) for (int k = 0; k < 5; k++) if (sw[k]) m_rw[d][k] = wd;
        @(negedge pclk);
        n_vec++;
        if (wr_pulse[d] !== (wr ? sw : 5'b0)) begin
            n_err++;
            $display("FAIL xfer_wr_pulse dut%0d: got %b expected %b", d, wr_pulse[d], wr ? sw : 5'b0);
        end
        n_vec++;
        if (rd_pulse[d] !== (wr ? 3'b0 : sr)) begin
            n_err++;
            $display("FAIL xfer_rd_pulse dut%0d: got %b expected %b", d, rd_pulse[d], wr ? 3'b0 : sr);
        end
        n_vec++;
        if (pready[d] !== 1'b0 || prdata[d] !== 8'h00) begin
            n_err++;
            $display("FAIL xfer_after_done dut%0d: got pready=%b prdata=%h expected 0/00", d, pready[d], prdata[d]);
        end
        n_vec++;
        if (rw_data[d] !== exp_rw(d)) begin
            n_err++;
            $display("FAIL xfer_rw_data dut%0d: got %h expected %h", d, rw_data[d], exp_rw(d));
        end
        idle_inputs(d);
        @(negedge pclk);
        n_vec++;
        if (wr_pulse[d] !== 5'b0 || rd_pulse[d] !== 3'b0) begin
            n_err++;
            $display("FAIL xfer_strobe_width dut%0d: got wr=%b rd=%b expected 0", d, wr_pulse[d], rd_pulse[d]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if (prdata[d] !== 8'h00 || pready[d] !== 1'b0 || wr_pulse[d] !== 5'b0 ||
                rd_pulse[d] !== 3'b0 || rw_data[d] !== 40'h0) begin
                n_err++;
                $display("FAIL %s dut%0d: got prdata=%h pready=%b wr=%b rd=%b rw=%h expected all 0",
                         tag, d, prdata[d], pready[d], wr_pulse[d], rd_pulse[d], rw_data[d]);
            end
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            idle_inputs(d);
            ro_data[d] = 24'h0;
        end
        model_reset();
        #13;
        check_reset_outputs("reset_initial");
        @(negedge pclk);
        presetn = 1'b1;
        // Complete a write, then reset asynchronously while the strobe is high
        @(negedge pclk);
        psel[0] = 1'b1; pwrite[0] = 1'b1; pselw[0] = 5'b01000; pwdata[0] = 8'hE7;
        @(negedge pclk);
        penable[0] = 1'b1;
        @(posedge pclk); #2;
        presetn = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        idle_inputs(0);
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    task automatic test_write_ws0();
        xfer(0, 1'b1, 5'b00100, 3'b000, 8'hA5, 1'b0, 24'h0);
    endtask

    task automatic test_ro_read_ws2();
        ro_data[1] = 24'h11_3C_22;
        xfer(1, 1'b0, 5'b00000, 3'b010, 8'h00, 1'b1, 24'h11_FF_22);
    endtask

    task automatic test_rw_readback();
        xfer(1, 1'b1, 5'b10000, 3'b000, 8'h5A, 1'b0, 24'h0);
        xfer(1, 1'b0, 5'b10000, 3'b000, 8'h00, 1'b0, 24'h0);
    endtask

    task automatic test_abort();
        @(negedge pclk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; pselw[2] = 5'b00001; pwdata[2] = 8'h77;
        @(negedge pclk);
        penable[2] = 1'b1;
        n_vec++;
        if (pready[2] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_pready_wait: got %b expected 0", pready[2]);
        end
        @(negedge pclk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge pclk);
        n_vec++;
        if (pready[2] !== 1'b0 || wr_pulse[2] !== 5'b0 || rw_data[2] !== exp_rw(2)) begin
            n_err++;
            $display("FAIL abort_state: got pready=%b wr=%b rw=%h expected 0/0/%h",
                     pready[2], wr_pulse[2], rw_data[2], exp_rw(2));
        end
        idle_inputs(2);
        xfer(2, 1'b1, 5'b00001, 3'b000, 8'h3E, 1'b0, 24'h0);
    endtask

    task automatic test_reset_mid_access();
        @(negedge pclk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; pselw[2] = 5'b00010; pwdata[2] = 8'h42;
        @(negedge pclk);
        penable[2] = 1'b1;
        @(negedge pclk); #2;
        presetn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (pready[2] !== 1'b0 || rw_data[2] !== 40'h0) begin
            n_err++;
            $display("FAIL reset_mid_access: got pready=%b rw=%h expected 0/0", pready[2], rw_data[2]);
        end
        for (int d = 0; d < NDUT; d++) idle_inputs(d);
        @(negedge pclk);
        presetn = 1'b1;
        xfer(2, 1'b1, 5'b00010, 3'b000, 8'h42, 1'b0, 24'h0);
    endtask

    task automatic test_random();
        int d, t, r;
        bit wr;
        logic [4:0] sw;
        logic [2:0] sr;
        for (int i = 0; i < 60; i++) begin
            d  = $urandom_range(0, NDUT - 1);
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 6) begin
                t  = $urandom_range(0, 7);
                sw = (t < 5) ? 5'(1 << t) : 5'b0;
                sr = (t >= 5) ? 3'(1 << (t - 5)) : 3'b0;
            end else if (r < 8) begin
                sw = 5'($urandom);
                sr = 3'($urandom);
            end else begin
                sw = 5'b0;
                sr = 3'b0;
            end
            ro_data[d] = 24'($urandom);
            xfer(d, wr, sw, sr, 8'($urandom), 1'($urandom_range(0, 1)), 24'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 5'b00001, 3'b000, 8'hC1, 1'b0, 24'h0);
        xfer(0, 1'b0, 5'b00001, 3'b000, 8'h00, 1'b0, 24'h0);
        xfer(0, 1'b1, 5'b00000, 3'b100, 8'hD2, 1'b0, 24'h0);
        xfer(0, 1'b0, 5'b00000, 3'b000, 8'h00, 1'b0, 24'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_ws0();
        test_ro_read_ws2();
        test_rw_readback();
        test_abort();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
